// File: rtl/psram_rr_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller between NUM_REQ layer engines.
// One single-word transaction at a time, with a watchdog on the controller's done.
module psram_rr_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int ADDR_WIDTH     = 24,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              req_rd_wr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   input  logic [NUM_REQ*3-1:0]            req_size,
   output logic [NUM_REQ-1:0]              gnt,
   output logic [NUM_REQ-1:0]              req_done,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic [ADDR_WIDTH-1:0]           ctrl_addr,
   output logic [DATA_WIDTH-1:0]           ctrl_wdata,
   output logic [2:0]                      ctrl_size,
   output logic                            ctrl_rd_wr,
   output logic                            ctrl_start,
   input  logic [DATA_WIDTH-1:0]           ctrl_rdata,
   input  logic                            ctrl_done,
   output logic                            busy,
   output logic                            timeout_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

   state_e                 state_q;
   logic [IDX_W-1:0]       ptr_q;
   logic [IDX_W-1:0]       win_q;
   logic [WD_W-1:0]        wd_q;
   logic [NUM_REQ-1:0]     gnt_q;
   logic [NUM_REQ-1:0]     req_done_q;
   logic [DATA_WIDTH-1:0]  rdata_q;
   logic [ADDR_WIDTH-1:0]  ctrl_addr_q;
   logic [DATA_WIDTH-1:0]  ctrl_wdata_q;
   logic [2:0]             ctrl_size_q;
   logic                   ctrl_rd_wr_q;
   logic                   ctrl_start_q;
   logic                   busy_q;
   logic                   timeout_err_q;

   logic                   win_vld_d;
   logic [IDX_W-1:0]       win_idx_d;
   logic [IDX_W:0]         cand_d;
   logic [NUM_REQ-1:0]     win_oh_d;
   logic [ADDR_WIDTH-1:0]  sel_addr_d;
   logic [DATA_WIDTH-1:0]  sel_wdata_d;
   logic [2:0]             sel_size_d;
   logic                   sel_rd_wr_d;
   logic [IDX_W-1:0]       ptr_nxt_d;
   logic                   wd_expire_d;

   // Search from the pointer upward with wrap; the first set bit wins.
   // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      win_vld_d = 1'b0;
      win_idx_d = '0;
      cand_d    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_d = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (cand_d >= (IDX_W+1)'(NUM_REQ)) cand_d = cand_d - (IDX_W+1)'(NUM_REQ);
         if (!win_vld_d && req[cand_d[IDX_W-1:0]]) begin
            win_vld_d = 1'b1;
            win_idx_d = cand_d[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      win_oh_d    = '0;
      sel_addr_d  = '0;
      sel_wdata_d = '0;
      sel_size_d  = '0;
      sel_rd_wr_d = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx_d == IDX_W'(i)) begin
            win_oh_d[i] = 1'b1;
            sel_addr_d  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata_d = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_size_d  = req_size[i*3 +: 3];
            sel_rd_wr_d = req_rd_wr[i];
         end
      end
   end

   assign ptr_nxt_d   = (win_q == IDX_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
   // The counter starts at 0 in the first WAIT cycle; expiry fires when its next value would be TIMEOUT_CYCLES-1.
   assign wd_expire_d = (wd_q == WD_W'(TIMEOUT_CYCLES-2));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         win_q         <= '0;
         wd_q          <= '0;
         gnt_q         <= '0;
         req_done_q    <= '0;
         rdata_q       <= '0;
         ctrl_addr_q   <= '0;
         ctrl_wdata_q  <= '0;
         ctrl_size_q   <= 3'b010;
         ctrl_rd_wr_q  <= 1'b0;
         ctrl_start_q  <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         req_done_q   <= '0;
         ctrl_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (win_vld_d) begin
                  state_q      <= ST_ISSUE;
                  busy_q       <= 1'b1;
                  gnt_q        <= win_oh_d;
                  win_q        <= win_idx_d;
                  ctrl_addr_q  <= sel_addr_d;
                  ctrl_wdata_q <= sel_wdata_d;
                  ctrl_size_q  <= sel_size_d;
                  ctrl_rd_wr_q <= sel_rd_wr_d;
                  ctrl_start_q <= 1'b1;
               end
            end
            ST_ISSUE: begin
               state_q <= ST_WAIT;
               wd_q    <= '0;
            end
            ST_WAIT: begin
               if (ctrl_done) begin
                  if (ctrl_rd_wr_q) rdata_q <= ctrl_rdata;
                  req_done_q <= gnt_q;
                  state_q    <= ST_RESP;
               end else if (wd_expire_d) begin
                  timeout_err_q <= 1'b1;
                  req_done_q    <= gnt_q;
                  state_q       <= ST_RESP;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            ST_RESP: begin
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               ptr_q   <= ptr_nxt_d;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt         = gnt_q;
   assign req_done    = req_done_q;
   assign rdata       = rdata_q;
   assign ctrl_addr   = ctrl_addr_q;
   assign ctrl_wdata  = ctrl_wdata_q;
   assign ctrl_size   = ctrl_size_q;
   assign ctrl_rd_wr  = ctrl_rd_wr_q;
   assign ctrl_start  = ctrl_start_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: doc/psram_rr_arbiter.md
Name: psram_rr_arbiter

Overview:
Round-robin arbiter sharing the single EF_PSRAM_CTRL_V2 instance between NUM_REQ layer engines (conv, maxpool, dense). It accepts one-word read/write requests and grants exactly one requester at a time. It drives the controller's addr/data_i/size/rd_wr/start, waits for controller done, and returns read data plus a done pulse to the winner. A watchdog flags a controller that never completes.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_WIDTH, 24, PSRAM byte address width
DATA_WIDTH, 32, controller data word width
TIMEOUT_CYCLES, 4096, max cycles from ctrl_start to ctrl_done before timeout (≥2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester request level
req_rd_wr  in  NUM_REQ  1=read, 0=write, per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
req_size  in  NUM_REQ*3  flattened size codes (3'b010 = 4 bytes)
gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
rdata  out  DATA_WIDTH  read data, valid in the req_done cycle, held until the next completion
ctrl_addr  out  ADDR_WIDTH  to controller addr
ctrl_wdata  out  DATA_WIDTH  to controller data_i
ctrl_size  out  3  to controller size
ctrl_rd_wr  out  1  to controller rd_wr
ctrl_start  out  1  to controller start, one-cycle pulse
ctrl_rdata  in  DATA_WIDTH  from controller data_o
ctrl_done  in  1  from controller done
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Reset (rst_n low at a clk edge, synchronous): state=IDLE; gnt=0, req_done=0, ctrl_start=0, busy=0, timeout_err=0, rdata=0, ctrl_addr/wdata/rd_wr=0, ctrl_size=3'b010, rr pointer=0. Reset mid-transaction aborts it; no req_done is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is high, select the first set bit searching from pointer upward with wrap (pointer, pointer+1, …, NUM_REQ-1, 0, …). At the edge, register gnt=onehot(winner) and latch the winner's addr/wdata/size/rd_wr into ctrl_*. Go to ISSUE. No req: stay.
- ISSUE (1 cycle): ctrl_start=1. Go to WAIT. A ctrl_done seen during ISSUE is ignored.
- WAIT: ctrl_start=0; the watchdog counter runs from 0. On ctrl_done: rdata<=ctrl_rdata (reads only; writes leave rdata unchanged); go to RESP. If the counter reaches TIMEOUT_CYCLES-1 without ctrl_done: set timeout_err and go to RESP (rdata unchanged). ctrl_done on the same cycle as expiry counts as done, with no error.
- RESP (1 cycle): req_done[winner]=1, gnt still high. Pointer<=(winner+1) mod NUM_REQ. At exit, gnt<=0 and state returns to IDLE.
- Latency: req high in IDLE at edge t gives gnt at t+1, ctrl_start during cycle t+1, and req_done exactly 1 cycle after the cycle that carries ctrl_done.
- Minimum idle gap: 1 IDLE cycle between transactions. Back-to-back requests from the same requester alternate with any other pending requester.
- ctrl_* are latched at grant. Requester fields may change after gnt without effect. Dropping req while granted does not cancel; the transaction completes and req_done still pulses.
- Requesters must not treat req_done as "new request accepted". req still high after req_done is a new request.
- ctrl_* outputs hold their values between transactions.

Test Plan:
- Single read: req=3'b001, addr0=24'h000100, rd_wr=1; ctrl_done after 5 cycles with ctrl_rdata=32'hDEADBEEF -> gnt=001 at t+1, one ctrl_start pulse with ctrl_addr=24'h000100, req_done=001 one cycle after ctrl_done, rdata=32'hDEADBEEF.
- Simultaneous contention: req=3'b111 held continuously, pointer=0 -> grant order 0,1,2,0; every ctrl_start matches that requester's latched addr. Never two gnt bits high.
- Write then read same requester with req1 also pending: req0 write wdata=32'h12345678, then req0 read -> req1 served between them; the write leaves rdata unchanged.
- Timeout: TIMEOUT_CYCLES=16, ctrl_done never asserted -> timeout_err rises 16 cycles after ctrl_start, req_done pulses, and the next request is still served. timeout_err stays high.
- Reset in WAIT: rst_n low for 1 edge -> all outputs at reset values next cycle, no req_done, pointer=0, timeout_err=0.
- Early done / field change: ctrl_done asserted during ISSUE and req_addr changed after gnt -> early done ignored, ctrl_addr unchanged, and completion only on the later ctrl_done in WAIT.
